// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder producing 32-bit schedule words
//
// Purpose:
//   Packs an incoming byte stream into big-endian 32-bit words. It then appends
//   the 0x80 terminator, zero fill and the 64-bit message bit length, so the
//   output is a whole number of 512-bit blocks for a SHA-256 core.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   message beat present
//   in_data    IN_W-bit beat, first byte in the MSBs
//   in_last    beat is the final beat of the message
//   in_nbytes  valid bytes on the last beat (0..IN_W/8)
//   in_ready   beat is accepted this cycle when in_valid is also high
//   w_valid    padded word present
//   w_data     padded word, big-endian
//   w_ready    downstream takes the word
//   w_first    word 0 of a 512-bit block
//   w_last     word 15 of a 512-bit block
//   msg_done   word 15 of the final block of the message
//   busy       a message is in progress

module sha256_padder #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  input  logic [2:0]      in_nbytes,
  output logic            in_ready,
  output logic            w_valid,
  output logic [31:0]     w_data,
  input  logic            w_ready,
  output logic            w_first,
  output logic            w_last,
  output logic            msg_done,
  output logic            busy
);

  localparam int         BPB  = IN_W / 8;
  localparam logic [2:0] BPB3 = 3'(BPB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_LEN_HI,
    S_LEN_LO
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] asm_q, asm_d;       // partially filled word, MSB-first
  logic [2:0]  cnt_q, cnt_d;       // bytes held in asm_q
  logic [63:0] len_q, len_d;       // message length in bits
  logic [3:0]  widx_q, widx_d;     // words transferred, modulo 16
  logic        need80_q, need80_d; // last beat filled its word; 0x80 goes in the next one

  // Output register
  logic        ov_q, ov_d;
  logic [31:0] od_q, od_d;
  logic        of_q, of_d;
  logic        ol_q, ol_d;
  logic        om_q, om_d;

  logic        out_free;
  logic        xfer;
  logic        accept;
  logic        needs_out;
  logic [3:0]  nidx;
  logic [2:0]  nb;
  logic [2:0]  total;
  logic [5:0]  sh_cnt;
  logic [5:0]  sh_nb;
  logic [5:0]  sh_tot;
  logic [31:0] beat_al;
  logic [31:0] beat_msk;
  logic [31:0] merged;
  logic [31:0] pad80;
  logic        load;
  logic [31:0] load_data;
  logic        load_done;

  // The output register can take a new word if it is empty or is draining this cycle.
  assign out_free = !ov_q || w_ready;
  assign xfer     = ov_q && w_ready;

  // The block index of the next word loaded. A word still in the register holds
  // index widx_q.
  assign nidx = widx_q + {3'b000, ov_q};

  // A beat needs the output register if it completes the word. A last beat always
  // queues a word, because that word carries the 0x80 byte or is full.
  assign needs_out = in_last || ((cnt_q + BPB3) >= 3'd4);
  assign in_ready  = ((state_q == S_IDLE) || (state_q == S_DATA)) && (!needs_out || out_free);
  assign accept    = in_valid && in_ready;

  assign nb     = in_last ? in_nbytes : BPB3;
  assign total  = cnt_q + nb;
  assign sh_cnt = {cnt_q, 3'b000};
  assign sh_nb  = {nb, 3'b000};
  assign sh_tot = {total, 3'b000};

  // Left-justify the beat, keep only its valid leading bytes, and slot it in
  // after the bytes already assembled.
  assign beat_al  = 32'(in_data) << (32 - IN_W);
  assign beat_msk = beat_al & ~(32'hFFFF_FFFF >> sh_nb);
  assign merged   = asm_q | (beat_msk >> sh_cnt);
  assign pad80    = 32'h8000_0000 >> sh_tot;

  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    need80_d  = need80_q;
    widx_d    = xfer ? (widx_q + 4'd1) : widx_q;
    ov_d      = xfer ? 1'b0 : ov_q;
    od_d      = od_q;
    of_d      = of_q;
    ol_d      = ol_q;
    om_d      = om_q;
    load      = 1'b0;
    load_data = 32'h0000_0000;
    load_done = 1'b0;

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          len_d = len_q + {58'd0, nb, 3'b000};
          if (in_last) begin
            load     = 1'b1;
            asm_d    = 32'h0000_0000;
            cnt_d    = 3'd0;
            state_d  = S_PAD;
            if (total >= 3'd4) begin
              load_data = merged;
              need80_d  = 1'b1;
            end else begin
              load_data = merged | pad80;
            end
          end else if (total >= 3'd4) begin
            load      = 1'b1;
            load_data = merged;
            asm_d     = 32'h0000_0000;
            cnt_d     = 3'd0;
            state_d   = S_DATA;
          end else begin
            asm_d   = merged;
            cnt_d   = total;
            state_d = S_DATA;
          end
        end
      end

      S_PAD: begin
        if (need80_q) begin
          if (out_free) begin
            load      = 1'b1;
            load_data = 32'h8000_0000;
            need80_d  = 1'b0;
          end
        end else if (nidx == 4'd14) begin
          state_d = S_LEN_HI;
        end else if (out_free) begin
          load      = 1'b1;
          load_data = 32'h0000_0000;
        end
      end

      S_LEN_HI: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = len_q[63:32];
          state_d   = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        // Once the final word sits in the register, leave when it is taken.
        if (ov_q && om_q) begin
          if (w_ready) begin
            state_d = S_IDLE;
            len_d   = 64'd0;
          end
        end else if (out_free) begin
          load      = 1'b1;
          load_data = len_q[31:0];
          load_done = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load) begin
      ov_d = 1'b1;
      od_d = load_data;
      of_d = (nidx == 4'd0);
      ol_d = (nidx == 4'd15);
      om_d = load_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      asm_q    <= 32'h0000_0000;
      cnt_q    <= 3'd0;
      len_q    <= 64'd0;
      widx_q   <= 4'd0;
      need80_q <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= 32'h0000_0000;
      of_q     <= 1'b0;
      ol_q     <= 1'b0;
      om_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      need80_q <= need80_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      of_q     <= of_d;
      ol_q     <= ol_d;
      om_q     <= om_d;
    end
  end

  assign w_valid  = ov_q;
  assign w_data   = od_q;
  assign w_first  = of_q;
  assign w_last   = ol_q;
  assign msg_done = om_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed bench for sha256_padder at IN_W 8, 16 and 32

module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // IN_W = 8 instance
  logic        in_valid8 = 1'b0, in_last8 = 1'b0, in_ready8;
  logic [7:0]  in_data8 = '0;
  logic [2:0]  in_nbytes8 = '0;
  logic        w_valid8, w_ready8 = 1'b1, w_first8, w_last8, msg_done8, busy8;
  logic [31:0] w_data8;

  // IN_W = 16 instance
  logic        in_valid16 = 1'b0, in_last16 = 1'b0, in_ready16;
  logic [15:0] in_data16 = '0;
  logic [2:0]  in_nbytes16 = '0;
  logic        w_valid16, w_ready16 = 1'b1, w_first16, w_last16, msg_done16, busy16;
  logic [31:0] w_data16;

  // IN_W = 32 instance
  logic        in_valid32 = 1'b0, in_last32 = 1'b0, in_ready32;
  logic [31:0] in_data32 = '0;
  logic [2:0]  in_nbytes32 = '0;
  logic        w_valid32, w_ready32 = 1'b1, w_first32, w_last32, msg_done32, busy32;
  logic [31:0] w_data32;

  sha256_padder #(.IN_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_data(in_data8), .in_last(in_last8),
    .in_nbytes(in_nbytes8), .in_ready(in_ready8), .w_valid(w_valid8), .w_data(w_data8),
    .w_ready(w_ready8), .w_first(w_first8), .w_last(w_last8), .msg_done(msg_done8), .busy(busy8)
  );

  sha256_padder #(.IN_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_data(in_data16), .in_last(in_last16),
    .in_nbytes(in_nbytes16), .in_ready(in_ready16), .w_valid(w_valid16), .w_data(w_data16),
    .w_ready(w_ready16), .w_first(w_first16), .w_last(w_last16), .msg_done(msg_done16), .busy(busy16)
  );

  sha256_padder #(.IN_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_data(in_data32), .in_last(in_last32),
    .in_nbytes(in_nbytes32), .in_ready(in_ready32), .w_valid(w_valid32), .w_data(w_data32),
    .w_ready(w_ready32), .w_first(w_first32), .w_last(w_last32), .msg_done(msg_done32), .busy(busy32)
  );

  // Transferred words as {msg_done, w_last, w_first, w_data}
  logic [34:0] q8[$];
  logic [34:0] q16[$];
  logic [34:0] q32[$];
  int          c32[$];

  always @(negedge clk) begin
    if (w_valid8 && w_ready8) q8.push_back({msg_done8, w_last8, w_first8, w_data8});
    if (w_valid16 && w_ready16) q16.push_back({msg_done16, w_last16, w_first16, w_data16});
    if (w_valid32 && w_ready32) begin
      q32.push_back({msg_done32, w_last32, w_first32, w_data32});
      c32.push_back(cyc);
    end
  end

  // Reference padding model
  logic [7:0]  msg[0:63];
  logic [34:0] exp_w[0:31];
  int          exp_n;

  task automatic model_pad(input int len);
    int          nblk;
    int          idx;
    logic [63:0] bl;
    logic [31:0] d;
    nblk  = (len + 9 + 63) / 64;
    exp_n = nblk * 16;
    bl    = 64'(len) * 64'd8;
    for (int w = 0; w < exp_n; w++) begin
      d = 32'h0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * w + j;
        d = {d[23:0], (idx < len) ? msg[idx] : ((idx == len) ? 8'h80 : 8'h00)};
      end
      if (w == exp_n - 2) d = bl[63:32];
      if (w == exp_n - 1) d = bl[31:0];
      exp_w[w] = {(w == exp_n - 1), ((w % 16) == 15), ((w % 16) == 0), d};
    end
  endtask

  task automatic beat8(input logic [7:0] d, input logic l, input logic [2:0] n);
    int t;
    in_valid8 = 1'b1; in_data8 = d; in_last8 = l; in_nbytes8 = n;
    t = 0;
    @(negedge clk);
    while (in_ready8 !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin nvec++; nerr++; $display("FAIL beat8_accept got in_ready=0 for 200 cycles exp 1"); end
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_last8 = 1'b0;
  endtask

  task automatic beat16(input logic [15:0] d, input logic l, input logic [2:0] n);
    int t;
    in_valid16 = 1'b1; in_data16 = d; in_last16 = l; in_nbytes16 = n;
    t = 0;
    @(negedge clk);
    while (in_ready16 !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin nvec++; nerr++; $display("FAIL beat16_accept got in_ready=0 for 200 cycles exp 1"); end
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_last16 = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input logic l, input logic [2:0] n);
    int t;
    in_valid32 = 1'b1; in_data32 = d; in_last32 = l; in_nbytes32 = n;
    t = 0;
    @(negedge clk);
    while (in_ready32 !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin nvec++; nerr++; $display("FAIL beat32_accept got in_ready=0 for 200 cycles exp 1"); end
    @(posedge clk); #1;
    in_valid32 = 1'b0; in_last32 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (in_ready8 !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %b exp 1", in_ready8); end
    nvec++; if (w_valid8 !== 1'b0) begin nerr++; $display("FAIL rst_w_valid got %b exp 0", w_valid8); end
    nvec++; if (w_data8 !== 32'h0) begin nerr++; $display("FAIL rst_w_data got %h exp 0", w_data8); end
    nvec++; if (w_first8 !== 1'b0) begin nerr++; $display("FAIL rst_w_first got %b exp 0", w_first8); end
    nvec++; if (w_last8 !== 1'b0) begin nerr++; $display("FAIL rst_w_last got %b exp 0", w_last8); end
    nvec++; if (msg_done8 !== 1'b0) begin nerr++; $display("FAIL rst_msg_done got %b exp 0", msg_done8); end
    nvec++; if (busy8 !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", busy8); end
    rst = 1'b1;
    @(posedge clk); #1;
    nvec++; if (in_ready8 !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready8 got %b exp 1", in_ready8); end
    nvec++; if (w_valid16 !== 1'b0) begin nerr++; $display("FAIL post_rst_w_valid16 got %b exp 0", w_valid16); end
    nvec++; if (in_ready32 !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready32 got %b exp 1", in_ready32); end
    nvec++; if (busy32 !== 1'b0) begin nerr++; $display("FAIL post_rst_busy32 got %b exp 0", busy32); end
  endtask

  task automatic test_abc;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    model_pad(3);
    q8.delete();
    w_ready8 = 1'b1;
    beat8(8'h61, 1'b0, 3'd1);
    beat8(8'h62, 1'b0, 3'd1);
    beat8(8'h63, 1'b1, 3'd1);
    for (int t = 0; t < 400 && q8.size() < exp_n; t++) @(negedge clk);
    @(posedge clk); #1;
    nvec++; if (q8.size() !== exp_n) begin nerr++; $display("FAIL abc_count got %0d exp %0d", q8.size(), exp_n); end
    for (int i = 0; i < exp_n && i < q8.size(); i++) begin
      nvec++; if (q8[i] !== exp_w[i]) begin nerr++; $display("FAIL abc_word%0d got %h exp %h", i, q8[i], exp_w[i]); end
    end
    nvec++; if (busy8 !== 1'b0) begin nerr++; $display("FAIL abc_busy_after got %b exp 0", busy8); end
  endtask

  task automatic test_empty;
    model_pad(0);
    q32.delete(); c32.delete();
    w_ready32 = 1'b1;
    beat32(32'hDEAD_BEEF, 1'b1, 3'd0);
    for (int t = 0; t < 400 && q32.size() < exp_n; t++) @(negedge clk);
    @(posedge clk); #1;
    nvec++; if (q32.size() !== exp_n) begin nerr++; $display("FAIL empty_count got %0d exp %0d", q32.size(), exp_n); end
    for (int i = 0; i < exp_n && i < q32.size(); i++) begin
      nvec++; if (q32[i] !== exp_w[i]) begin nerr++; $display("FAIL empty_word%0d got %h exp %h", i, q32[i], exp_w[i]); end
    end
  endtask

  task automatic test_two_block;
    for (int i = 0; i < 56; i++) msg[i] = 8'(i * 3 + 1);
    model_pad(56);
    q32.delete(); c32.delete();
    w_ready32 = 1'b1;
    for (int b = 0; b < 14; b++)
      beat32({msg[4*b], msg[4*b+1], msg[4*b+2], msg[4*b+3]}, (b == 13), 3'd4);
    for (int t = 0; t < 600 && q32.size() < exp_n; t++) @(negedge clk);
    @(posedge clk); #1;
    nvec++; if (q32.size() !== exp_n) begin nerr++; $display("FAIL two_block_count got %0d exp %0d", q32.size(), exp_n); end
    for (int i = 0; i < exp_n && i < q32.size(); i++) begin
      nvec++; if (q32[i] !== exp_w[i]) begin nerr++; $display("FAIL two_block_word%0d got %h exp %h", i, q32[i], exp_w[i]); end
    end
    if (c32.size() >= 14) begin
      nvec++;
      if (c32[13] - c32[0] !== 13) begin
        nerr++; $display("FAIL two_block_rate got %0d cycles exp 13", c32[13] - c32[0]);
      end
    end
  endtask

  task automatic test_bytes55;
    for (int i = 0; i < 55; i++) msg[i] = 8'(i + 8'h10);
    model_pad(55);
    q8.delete();
    w_ready8 = 1'b1;
    for (int i = 0; i < 55; i++) beat8(msg[i], (i == 54), 3'd1);
    for (int t = 0; t < 600 && q8.size() < exp_n; t++) @(negedge clk);
    @(posedge clk); #1;
    nvec++; if (q8.size() !== exp_n) begin nerr++; $display("FAIL b55_count got %0d exp %0d", q8.size(), exp_n); end
    for (int i = 0; i < exp_n && i < q8.size(); i++) begin
      nvec++; if (q8[i] !== exp_w[i]) begin nerr++; $display("FAIL b55_word%0d got %h exp %h", i, q8[i], exp_w[i]); end
    end
  endtask

  task automatic test_stall;
    logic        pv;
    logic [31:0] pd;
    for (int i = 0; i < 20; i++) msg[i] = 8'(8'hA0 + i);
    model_pad(20);
    q16.delete();
    w_ready16 = 1'b1;
    fork
      begin
        for (int b = 0; b < 10; b++) beat16({msg[2*b], msg[2*b+1]}, (b == 9), 3'd2);
      end
      begin
        repeat (3 + $urandom_range(0, 2)) @(posedge clk);
        #1 w_ready16 = 1'b0;
        pv = 1'b0; pd = 32'h0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (pv) begin
            nvec++;
            if (w_valid16 !== 1'b1 || w_data16 !== pd) begin
              nerr++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", w_valid16, w_data16, pd);
            end
          end
          pv = w_valid16; pd = w_data16;
        end
        nvec++; if (in_ready16 !== 1'b0) begin nerr++; $display("FAIL stall_in_ready got %b exp 0", in_ready16); end
        @(posedge clk); #1 w_ready16 = 1'b1;
      end
    join
    for (int t = 0; t < 600 && q16.size() < exp_n; t++) @(negedge clk);
    @(posedge clk); #1;
    nvec++; if (q16.size() !== exp_n) begin nerr++; $display("FAIL stall_count got %0d exp %0d", q16.size(), exp_n); end
    for (int i = 0; i < exp_n && i < q16.size(); i++) begin
      nvec++; if (q16[i] !== exp_w[i]) begin nerr++; $display("FAIL stall_word%0d got %h exp %h", i, q16[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid;
    q8.delete();
    w_ready8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      beat8(8'(8'h30 + i), (i == 39), 3'd1);
      if (q8.size() >= 7) break;
    end
    nvec++; if (q8.size() < 7) begin nerr++; $display("FAIL mid_reached_word7 got %0d words exp >=7", q8.size()); end
    rst = 1'b0;
    #1;
    nvec++; if (in_ready8 !== 1'b1) begin nerr++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready8); end
    nvec++; if (w_valid8 !== 1'b0) begin nerr++; $display("FAIL mid_rst_w_valid got %b exp 0", w_valid8); end
    nvec++; if (w_data8 !== 32'h0) begin nerr++; $display("FAIL mid_rst_w_data got %h exp 0", w_data8); end
    nvec++; if (w_first8 !== 1'b0) begin nerr++; $display("FAIL mid_rst_w_first got %b exp 0", w_first8); end
    nvec++; if (w_last8 !== 1'b0) begin nerr++; $display("FAIL mid_rst_w_last got %b exp 0", w_last8); end
    nvec++; if (msg_done8 !== 1'b0) begin nerr++; $display("FAIL mid_rst_msg_done got %b exp 0", msg_done8); end
    nvec++; if (busy8 !== 1'b0) begin nerr++; $display("FAIL mid_rst_busy got %b exp 0", busy8); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    model_pad(3);
    q8.delete();
    beat8(8'h61, 1'b0, 3'd1);
    beat8(8'h62, 1'b0, 3'd1);
    beat8(8'h63, 1'b1, 3'd1);
    for (int t = 0; t < 400 && q8.size() < exp_n; t++) @(negedge clk);
    @(posedge clk); #1;
    nvec++; if (q8.size() !== exp_n) begin nerr++; $display("FAIL mid_abc_count got %0d exp %0d", q8.size(), exp_n); end
    for (int i = 0; i < exp_n && i < q8.size(); i++) begin
      nvec++; if (q8[i] !== exp_w[i]) begin nerr++; $display("FAIL mid_abc_word%0d got %h exp %h", i, q8[i], exp_w[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_abc;
    test_empty;
    test_two_block;
    test_bytes55;
    test_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 Parameter IN_W, default 8, input beat width in bits; SHALL be 8, 16 or 32.
REQ-002 Port clk  input  1  rising-edge clock, sole clock.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  message beat present.
REQ-005 Port in_data  input  IN_W  message bytes, big-endian (first byte in MSBs).
REQ-006 Port in_last  input  1  beat is final beat of message.
REQ-007 Port in_nbytes  input  3  valid bytes on last beat, 0..IN_W/8; ignored when in_last=0.
REQ-008 Port in_ready  output  1  block accepts a beat this cycle.
REQ-009 Port w_valid  output  1  padded 32-bit schedule word present.
REQ-010 Port w_data  output  32  padded message word, big-endian.
REQ-011 Port w_ready  input  1  downstream SHA core takes word.
REQ-012 Port w_first  output  1  w_data is word 0 of a 512-bit block.
REQ-013 Port w_last  output  1  w_data is word 15 of a block.
REQ-014 Port msg_done  output  1  w_data is word 15 of the final block of the message.
REQ-015 Port busy  output  1  message in progress (not IDLE).

Function
REQ-016 Beat accepted iff in_valid && in_ready; word transferred iff w_valid && w_ready.
REQ-017 Accepted bytes SHALL pack MSB-first into a 32-bit assembly word; a full word SHALL move to the output register and w_valid SHALL assert the following cycle.
REQ-018 w_data, w_first, w_last, msg_done SHALL hold stable while w_valid=1 and w_ready=0.
REQ-019 in_ready SHALL deassert when accepting a beat would overflow the assembly word while the output register is still occupied, and in states PAD, LEN_HI, LEN_LO.
REQ-020 FSM states: IDLE, DATA, PAD, LEN_HI, LEN_LO.
REQ-021 IDLE->DATA on the first accepted beat; IDLE->PAD directly on an accepted beat with in_last=1, in_nbytes=0 (empty message).
REQ-022 On accepted in_last beat: only in_nbytes bytes counted; byte 0x80 SHALL be appended immediately after them; remaining bytes of that word zero.
REQ-023 DATA->PAD after the word holding 0x80 is queued.
REQ-024 PAD SHALL emit 0x00000000 words until word index 14 is next; if the 0x80 word landed at index 14 or 15, PAD SHALL zero-fill to word 15, then continue in a new block to word 14.
REQ-025 LEN_HI emits bits [63:32] of message bit length at word 14; LEN_LO emits bits [31:0] at word 15 with w_last=1, msg_done=1; LEN_LO->IDLE on transfer.
REQ-026 Bit length counter 64 bits, += 8*bytes per accepted beat, wraps modulo 2^64.
REQ-027 Word index counter 4 bits, increments per transfer, wraps 15->0; w_first=1 at index 0, w_last=1 at index 15 for every block.
REQ-028 msg_done SHALL assert only on the final block's word 15, never on an intermediate block.
REQ-029 Zero-state throughput: one word per cycle when w_ready=1 continuously (IN_W=32).
REQ-030 in_nbytes > IN_W/8 is illegal; behaviour unspecified, no hang required to be detected.

Reset
REQ-031 rst=0 SHALL immediately clear FSM to IDLE, counters to 0, assembly and output registers to 0.
REQ-032 During and after reset until first beat: in_ready=1, w_valid=0, w_data=0, w_first=0, w_last=0, msg_done=0, busy=0.
REQ-033 Reset mid-message SHALL discard the message; the next message after release SHALL pad correctly.

Verification
REQ-034 IN_W=8, bytes 61,62,63, in_last on 63, w_ready=1 -> words 0x61626380, 14x 0x00000000, 0x00000018; w_first on word0; w_last and msg_done on word15.
REQ-035 IN_W=32, single beat in_last=1, in_nbytes=0 -> 0x80000000, 14x 0x00000000, 0x00000000; msg_done on word15.
REQ-036 IN_W=32, 56-byte message (14 beats, last in_nbytes=4) -> block1: 14 data, 0x80000000, 0x00000000, w_last=1, msg_done=0; block2: 14x 0, 0x00000000, 0x000001C0, msg_done=1.
REQ-037 IN_W=8, 55 bytes -> single block; word13 = bytes 52..54 followed by 0x80; word15 = 0x000001B8.
REQ-038 IN_W=16, random w_ready low for 5 cycles mid-message -> w_data stable while stalled, in_ready low when full, word sequence identical to unstalled run.
REQ-039 rst=0 asserted during word 7 of a message -> all outputs at reset values within the same cycle; after release, "abc" yields REQ-034 sequence.
